mem_access_unit: RTL

//  Data-memory master for the MEM stage. Takes the load/store request from EX/MEM,

---
 rtl/mem_access_unit_if.sv | 20 ++
 rtl/mem_access_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between mem_access_unit (master) and the memory (slave).
//   req    master->slave  request, held until ack
//   we     master->slave  1 = write
//   addr   master->slave  word address
//   be     master->slave  byte enables
//   wdata  master->slave  lane-replicated store data
//   rdata  slave->master  read data, valid with ack
//   ack    slave->master  transaction complete
interface mem_access_unit_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (output req, we, addr, be, wdata, input rdata, ack);
    modport slave  (input req, we, addr, be, wdata, output rdata, ack);
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory master. Runs one req/ack bus transaction per aligned
// load/store, returns the aligned and extended load word on d_mem, and holds
// the pipeline through stall_req until the access completes.
//   clk, rst        clock, synchronous active-high reset
//   mem_rd, mem_wr  load / store in MEM (both set = store)
//   funct3          size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU, others W
//   addr, wdata     byte address and store data
//   stall_req       combinational freeze request to the stall controller
//   d_mem           extended load result to MEM/WB
//   misalign        one-cycle pulse per misaligned access presented in IDLE
//   bus_err         one-cycle pulse when TIMEOUT BUSY cycles pass without ack
//   bus             master side of the data-memory bus
module mem_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_rd,
    input  logic               mem_wr,
    input  logic [2:0]         funct3,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic               stall_req,
    output logic [31:0]        d_mem,
    output logic               misalign,
    output logic               bus_err,
    mem_access_unit_if.master  bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] d_mem_q, d_mem_d;
    logic        mis_q, mis_d;
    logic        err_q, err_d;
    logic [31:0] cnt_q, cnt_d;

    logic access;
    logic aligned;

    // size code: 00 byte, 01 half, anything else word (reserved codes included)
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 1'b1;
            2'b01:   return ~off[0];
            default: return off == 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    // funct3[2] selects zero extension for the sub-word loads
    function automatic logic [31:0] load_extend(input logic [31:0] rd, input logic [2:0] f3,
                                                input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{off, 3'b000} +: 8];
        h = rd[{off[1], 4'b0000} +: 16];
        case (f3[1:0])
            2'b00:   return f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   return f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
            default: return rd;
        endcase
    endfunction

    assign access  = mem_rd | mem_wr;
    assign aligned = is_aligned(funct3[1:0], addr[1:0]);

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        f3_d      = f3_q;
        off_d     = off_q;
        d_mem_d   = d_mem_q;
        mis_d     = 1'b0;
        err_d     = 1'b0;
        cnt_d     = cnt_q;
        stall_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (aligned) begin
                        stall_req = 1'b1;
                        req_d     = 1'b1;
                        we_d      = mem_wr;
                        addr_d    = {addr[31:2], 2'b00};
                        be_d      = mem_wr ? store_be(funct3[1:0], addr[1:0]) : 4'b1111;
                        wdata_d   = store_lanes(funct3[1:0], wdata);
                        f3_d      = funct3;
                        off_d     = addr[1:0];
                        cnt_d     = '0;
                        state_d   = BUSY;
                    end else begin
                        mis_d   = 1'b1;
                        d_mem_d = '0;
                    end
                end
            end
            BUSY: begin
                stall_req = 1'b1;
                if (bus.ack) begin
                    req_d   = 1'b0;
                    if (!we_q) d_mem_d = load_extend(bus.rdata, f3_q, off_q);
                    state_d = DONE;
                end else if (TIMEOUT > 0 && cnt_q == 32'(TIMEOUT - 1)) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    d_mem_d = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            // One dead cycle so the completing instruction is not reissued
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (rst) stall_req = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            d_mem_q <= '0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            d_mem_q <= d_mem_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.req   = req_q;
    assign bus.we    = we_q;
    assign bus.addr  = addr_q;
    assign bus.be    = be_q;
    assign bus.wdata = wdata_q;
    assign d_mem     = d_mem_q;
    assign misalign  = mis_q;
    assign bus_err   = err_q;

endmodule
